// File: rtl/piece_pixel_pipe.sv
// Pixel back-end: sprite ROM addressing, blinking cursor overlay and 12-bit VGA colour resolve.
// Latency: 3 register stages for colour and syncs alike; one pixel per clock, no backpressure.
module piece_pixel_pipe #(
  parameter int BORDER     = 3,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [11:0] pixel_addr,
  input  logic [3:0]  img_addr,
  input  logic        board_on,
  input  logic        background_index,
  input  logic [2:0]  cursor_x,
  input  logic [2:0]  cursor_y,
  input  logic        cursor_en,
  output logic [15:0] rom_addr,
  input  logic [1:0]  rom_data,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic        hs_out,
  output logic        vs_out
);

  localparam logic [9:0]  SQ_SIZE     = 10'd60;
  localparam logic [9:0]  BOARD_W     = 10'd480;
  localparam logic [9:0]  B_LO        = 10'(BORDER);
  localparam logic [9:0]  B_HI        = 10'(60 - BORDER);
  localparam logic [15:0] SPRITE_SIZE = 16'd3600;
  localparam logic [BLINK_LOG2-1:0] FRAME_ONE = {{(BLINK_LOG2-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic board_on;
    logic bg;
    logic piece_valid;
    logic is_white;
    logic cur_hit;
  } attr_t;

  localparam attr_t ATTR_RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1, default: 1'b0};

  // Frame event tracking and cursor latch
  logic                  vs_q;
  logic                  frame_evt;
  logic [2:0]            cur_x_l;
  logic [2:0]            cur_y_l;
  logic                  cur_en_l;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  blink_on;

  assign frame_evt = vs_q & ~vs_in;
  assign blink_on  = ~frame_cnt[BLINK_LOG2-1];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vs_q      <= 1'b1;
      cur_x_l   <= 3'd0;
      cur_y_l   <= 3'd0;
      cur_en_l  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_q <= vs_in;
      if (frame_evt) begin
        cur_x_l   <= cursor_x;
        cur_y_l   <= cursor_y;
        cur_en_l  <= cursor_en;
        frame_cnt <= frame_cnt + FRAME_ONE;
      end
    end
  end

  // Stage A combinational: square position, border test, sprite address
  logic [9:0]  sq_col;
  logic [9:0]  sq_row;
  logic [9:0]  off_x;
  logic [9:0]  off_y;
  logic        on_sq;
  logic        on_edge;
  logic        piece_valid_c;
  logic [15:0] addr_c;
  attr_t       attr_c;

  assign sq_col  = DrawX / SQ_SIZE;
  assign sq_row  = DrawY / SQ_SIZE;
  assign off_x   = DrawX % SQ_SIZE;
  assign off_y   = DrawY % SQ_SIZE;
  assign on_sq   = (DrawX < BOARD_W) && (sq_col == {7'd0, cur_x_l}) && (sq_row == {7'd0, cur_y_l});
  assign on_edge = (off_x < B_LO) || (off_x >= B_HI) || (off_y < B_LO) || (off_y >= B_HI);

  assign piece_valid_c = (img_addr <= 4'hB);
  assign addr_c = piece_valid_c ? (16'(img_addr) * SPRITE_SIZE + 16'(pixel_addr)) : 16'd0;

  always_comb begin
    attr_c             = ATTR_RST;
    attr_c.de          = de_in;
    attr_c.hs          = hs_in;
    attr_c.vs          = vs_in;
    attr_c.board_on    = board_on;
    attr_c.bg          = background_index;
    attr_c.piece_valid = piece_valid_c;
    attr_c.is_white    = img_addr[0];
    attr_c.cur_hit     = on_sq & on_edge;
  end

  // Stage A and B registers; stage B waits out the ROM read
  attr_t attr_a;
  attr_t attr_b;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rom_addr <= 16'd0;
      attr_a   <= ATTR_RST;
      attr_b   <= ATTR_RST;
    end else begin
      rom_addr <= addr_c;
      attr_a   <= attr_c;
      attr_b   <= attr_a;
    end
  end

  // Stage C: colour priority resolve
  logic [11:0] rgb_c;

  always_comb begin
    rgb_c = 12'h000;
    if (!attr_b.de) begin
      rgb_c = 12'h000;
    end else if (attr_b.cur_hit && cur_en_l && blink_on) begin
      rgb_c = 12'h0F0;
    end else if (!attr_b.board_on) begin
      rgb_c = 12'h222;
    end else if (attr_b.piece_valid && rom_data == 2'd1) begin
      rgb_c = attr_b.is_white ? 12'hFFF : 12'h111;
    end else if (attr_b.piece_valid && rom_data == 2'd2) begin
      rgb_c = attr_b.is_white ? 12'h000 : 12'hCCC;
    end else begin
      rgb_c = attr_b.bg ? 12'h864 : 12'hEDB;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Red    <= 4'h0;
      Green  <= 4'h0;
      Blue   <= 4'h0;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
    end else begin
      {Red, Green, Blue} <= rgb_c;
      hs_out             <= attr_b.hs;
      vs_out             <= attr_b.vs;
    end
  end

endmodule

// File: tb/tb_piece_pixel_pipe.sv
// Bench for piece_pixel_pipe: directed scenarios plus random traffic against a pixel-level reference model.
module tb_piece_pixel_pipe;

  localparam int BORDER     = 3;
  localparam int BLINK_LOG2 = 5;
  localparam int PERIOD     = 1 << BLINK_LOG2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic [11:0] pixel_addr = '0;
  logic [3:0]  img_addr = 4'hC;
  logic        board_on = 1'b0, background_index = 1'b0;
  logic [2:0]  cursor_x = '0, cursor_y = '0;
  logic        cursor_en = 1'b0;
  logic [15:0] rom_addr;
  logic [1:0]  rom_data = 2'd0;
  logic [3:0]  Red, Green, Blue;
  logic        hs_out, vs_out;

  piece_pixel_pipe #(.BORDER(BORDER), .BLINK_LOG2(BLINK_LOG2)) dut (
    .CLK(CLK), .RESET(RESET), .DrawX(DrawX), .DrawY(DrawY),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .pixel_addr(pixel_addr), .img_addr(img_addr), .board_on(board_on),
    .background_index(background_index),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .Red(Red), .Green(Green), .Blue(Blue), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 CLK = ~CLK;

  // External one-cycle synchronous sprite ROM, with an override for directed tests
  logic       rom_force = 1'b0;
  logic [1:0] rom_force_val = 2'd0;

  function automatic logic [1:0] rom_fn(logic [15:0] a);
    return 2'(a ^ (a >> 3) ^ (a >> 7));
  endfunction

  always @(posedge CLK) rom_data <= rom_force ? rom_force_val : rom_fn(rom_addr);

  // Reference model: one record per pixel, colour resolved two clocks after sampling
  typedef struct {
    logic de, hs, vs, board_on, bg, pv, white, hit;
    logic [15:0] addr;
    logic [1:0]  code;
  } pix_t;

  pix_t        q[$];
  int          m_frame;
  int          m_cx, m_cy;
  logic        m_en, m_vsq;
  logic [13:0] exp_px;
  logic [15:0] exp_addr;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic cursor_hit(int x, int y, int cx, int cy);
    int ox, oy;
    ox = x % 60;
    oy = y % 60;
    return (x < 480) && (x / 60 == cx) && (y / 60 == cy) &&
           (ox < BORDER || ox >= 60 - BORDER || oy < BORDER || oy >= 60 - BORDER);
  endfunction

  function automatic logic [11:0] colour(pix_t p, logic en, int frame);
    if (!p.de) return 12'h000;
    if (p.hit && en && (frame % PERIOD) < PERIOD / 2) return 12'h0F0;
    if (!p.board_on) return 12'h222;
    if (p.pv && p.code == 2'd1) return p.white ? 12'hFFF : 12'h111;
    if (p.pv && p.code == 2'd2) return p.white ? 12'h000 : 12'hCCC;
    return p.bg ? 12'h864 : 12'hEDB;
  endfunction

  task automatic model_reset();
    pix_t blank;
    blank = '{de: 1'b0, hs: 1'b1, vs: 1'b1, board_on: 1'b0, bg: 1'b0, pv: 1'b0,
              white: 1'b0, hit: 1'b0, addr: 16'd0, code: 2'd0};
    q.delete();
    q.push_back(blank);
    q.push_back(blank);
    m_frame = 0; m_cx = 0; m_cy = 0; m_en = 1'b0; m_vsq = 1'b1;
  endtask

  // Advance one clock: form expectations for this edge, then sample #1 after it
  task automatic step();
    pix_t p, prev, old;
    prev = q.pop_back();
    prev.code = rom_force ? rom_force_val : rom_fn(prev.addr);
    q.push_back(prev);
    old = q.pop_front();
    exp_px = {colour(old, m_en, m_frame), old.hs, old.vs};
    p.de = de_in; p.hs = hs_in; p.vs = vs_in; p.board_on = board_on;
    p.bg = background_index; p.pv = (img_addr <= 4'hB); p.white = img_addr[0];
    p.addr = p.pv ? 16'(int'(img_addr) * 3600 + int'(pixel_addr)) : 16'd0;
    p.hit = cursor_hit(int'(DrawX), int'(DrawY), m_cx, m_cy);
    p.code = 2'd0;
    q.push_back(p);
    exp_addr = p.addr;
    if (m_vsq && !vs_in) begin
      m_cx = int'(cursor_x); m_cy = int'(cursor_y); m_en = cursor_en;
      m_frame++;
    end
    m_vsq = vs_in;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(int x, int y, logic de, logic bon, logic [3:0] img, logic [11:0] pa, logic bg);
    DrawX = 10'(x); DrawY = 10'(y); de_in = de; board_on = bon;
    img_addr = img; pixel_addr = pa; background_index = bg;
  endtask

  task automatic rand_pix();
    DrawX = 10'($urandom_range(0, 639));
    DrawY = 10'($urandom_range(0, 524));
    board_on = (DrawX < 10'd480);
    de_in = ($urandom_range(0, 7) != 0);
    hs_in = ($urandom_range(0, 9) != 0);
    img_addr = 4'($urandom);
    pixel_addr = 12'($urandom_range(0, 3599));
    background_index = 1'($urandom);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #3;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #12;
    n_tests++;
    if ({Red, Green, Blue, hs_out, vs_out, rom_addr} !== {12'h000, 2'b11, 16'd0}) begin
      n_fail++; $display("FAIL reset_hold got %h want %h", {Red, Green, Blue, hs_out, vs_out, rom_addr}, {12'h000, 2'b11, 16'd0});
    end
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      rand_pix();
      step();
      n_tests++;
      if ({Red, Green, Blue, hs_out, vs_out, rom_addr} !== {exp_px, exp_addr}) begin
        n_fail++; $display("FAIL reset_traffic got %h want %h", {Red, Green, Blue, hs_out, vs_out, rom_addr}, {exp_px, exp_addr});
      end
    end
    hs_in = 1'b1;
    drive(500, 100, 1'b1, 1'b0, 4'h3, 12'd7, 1'b0);
    for (int i = 0; i < 3; i++) step();
    #2;
    RESET = 1'b1;
    #1;
    n_tests++;
    if ({Red, Green, Blue, hs_out, vs_out, rom_addr} !== {12'h000, 2'b11, 16'd0}) begin
      n_fail++; $display("FAIL reset_midline got %h want %h", {Red, Green, Blue, hs_out, vs_out, rom_addr}, {12'h000, 2'b11, 16'd0});
    end
    #1;
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({Red, Green, Blue, hs_out, vs_out, rom_addr} !== {exp_px, exp_addr}) begin
        n_fail++; $display("FAIL reset_release got %h want %h", {Red, Green, Blue, hs_out, vs_out, rom_addr}, {exp_px, exp_addr});
      end
    end
    n_tests++;
    if ({Red, Green, Blue} !== 12'h222) begin
      n_fail++; $display("FAIL reset_follow got %h want %h", {Red, Green, Blue}, 12'h222);
    end
  endtask

  task automatic test_piece();
    rom_force = 1'b1; rom_force_val = 2'd1;
    drive(200, 100, 1'b1, 1'b1, 4'h5, 12'd100, 1'b0);
    step();
    n_tests++;
    if (rom_addr !== 16'd18100) begin
      n_fail++; $display("FAIL piece_addr got %0d want %0d", rom_addr, 18100);
    end
    for (int i = 0; i < 2; i++) step();
    n_tests++;
    if ({Red, Green, Blue, hs_out, vs_out} !== {12'hFFF, 2'b11}) begin
      n_fail++; $display("FAIL piece_body got %h want %h", {Red, Green, Blue}, 12'hFFF);
    end
    rom_force_val = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({Red, Green, Blue, hs_out, vs_out, rom_addr} !== {exp_px, exp_addr}) begin
        n_fail++; $display("FAIL piece_model got %h want %h", {Red, Green, Blue, hs_out, vs_out, rom_addr}, {exp_px, exp_addr});
      end
    end
    n_tests++;
    if ({Red, Green, Blue} !== 12'hEDB) begin
      n_fail++; $display("FAIL piece_transparent got %h want %h", {Red, Green, Blue}, 12'hEDB);
    end
  endtask

  task automatic test_empty();
    rom_force = 1'b1; rom_force_val = 2'd1;
    drive(260, 70, 1'b1, 1'b1, 4'hC, 12'd555, 1'b1);
    step();
    n_tests++;
    if (rom_addr !== 16'd0) begin
      n_fail++; $display("FAIL empty_addr got %0d want %0d", rom_addr, 0);
    end
    for (int i = 0; i < 2; i++) step();
    n_tests++;
    if ({Red, Green, Blue} !== 12'h864) begin
      n_fail++; $display("FAIL empty_colour got %h want %h", {Red, Green, Blue}, 12'h864);
    end
    rom_force = 1'b0;
  endtask

  task automatic test_offboard();
    drive(500, 50, 1'b1, 1'b0, 4'h2, 12'd9, 1'b0);
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if ({Red, Green, Blue} !== 12'h222) begin
      n_fail++; $display("FAIL offboard got %h want %h", {Red, Green, Blue}, 12'h222);
    end
    de_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if ({Red, Green, Blue} !== 12'h000) begin
      n_fail++; $display("FAIL blank got %h want %h", {Red, Green, Blue}, 12'h000);
    end
    hs_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (hs_out !== 1'b1) begin
        n_fail++; $display("FAIL hs_early cycle %0d got %b want 1", i, hs_out);
      end
    end
    step();
    n_tests++;
    if (hs_out !== 1'b0) begin
      n_fail++; $display("FAIL hs_delay got %b want 0", hs_out);
    end
    hs_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_cursor();
    cursor_x = 3'd2; cursor_y = 3'd3; cursor_en = 1'b1;
    drive(121, 181, 1'b1, 1'b1, 4'hC, 12'd0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if ({Red, Green, Blue} !== 12'hEDB) begin
      n_fail++; $display("FAIL cursor_midframe got %h want %h", {Red, Green, Blue}, 12'hEDB);
    end
    vs_in = 1'b0; step();
    vs_in = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({Red, Green, Blue, hs_out, vs_out, rom_addr} !== {exp_px, exp_addr}) begin
        n_fail++; $display("FAIL cursor_model got %h want %h", {Red, Green, Blue, hs_out, vs_out, rom_addr}, {exp_px, exp_addr});
      end
    end
    n_tests++;
    if ({Red, Green, Blue} !== 12'h0F0) begin
      n_fail++; $display("FAIL cursor_border got %h want %h", {Red, Green, Blue}, 12'h0F0);
    end
    drive(150, 210, 1'b1, 1'b1, 4'h5, 12'd1830, 1'b1);
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if ({Red, Green, Blue} !== exp_px[13:2] || exp_px[13:2] === 12'h0F0) begin
      n_fail++; $display("FAIL cursor_inner got %h want %h", {Red, Green, Blue}, exp_px[13:2]);
    end
  endtask

  task automatic test_blink();
    logic [11:0] want;
    do_reset();
    cursor_x = 3'd2; cursor_y = 3'd3; cursor_en = 1'b1;
    drive(121, 181, 1'b1, 1'b1, 4'hC, 12'd0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    for (int e = 1; e <= 48; e++) begin
      vs_in = 1'b0; step();
      vs_in = 1'b1; step();
      for (int i = 0; i < 3; i++) begin
        step();
        n_tests++;
        if ({Red, Green, Blue, hs_out, vs_out} !== exp_px) begin
          n_fail++; $display("FAIL blink_model frame %0d got %h want %h", e, {Red, Green, Blue, hs_out, vs_out}, exp_px);
        end
      end
      want = ((e % 32) < 16) ? 12'h0F0 : 12'hEDB;
      n_tests++;
      if ({Red, Green, Blue} !== want) begin
        n_fail++; $display("FAIL blink frame_cnt %0d got %h want %h", e % 32, {Red, Green, Blue}, want);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rand_pix();
      vs_in = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) begin
        cursor_x = 3'($urandom); cursor_y = 3'($urandom); cursor_en = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        DrawX = 10'(int'(cursor_x) * 60 + $urandom_range(0, 59));
        DrawY = 10'(int'(cursor_y) * 60 + $urandom_range(0, 59));
        board_on = 1'b1;
      end
      step();
      n_tests++;
      if ({Red, Green, Blue, hs_out, vs_out, rom_addr} !== {exp_px, exp_addr}) begin
        n_fail++; $display("FAIL random step %0d got %h want %h", i, {Red, Green, Blue, hs_out, vs_out, rom_addr}, {exp_px, exp_addr});
      end
    end
    vs_in = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_piece();
    test_empty();
    test_offboard();
    test_cursor();
    test_blink();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
